// File: rtl/ospfb_capture_ctrl.sv
// Capture sequencer: waits for a frame boundary after arm, then writes FRAMES*FFT_LEN
// beats of the OSPFB stream to capture RAM while checking alignment and FFT events.
module ospfb_capture_ctrl #(
    parameter int unsigned FFT_LEN    = 128,
    parameter int unsigned FRAMES     = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NFFT       = 2,
    parameter int unsigned CNT_WIDTH  = 16,
    localparam int unsigned ADDR_W    = $clog2(FRAMES * FFT_LEN),
    localparam int unsigned IDX_W     = $clog2(FFT_LEN)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic [NFFT-1:0]       event_fft_overflow,
    input  logic [NFFT-1:0]       event_tlast_unexpected,
    input  logic [NFFT-1:0]       event_tlast_missing,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  full,
    output logic                  busy,
    output logic [1:0]            state,
    output logic                  align_err,
    output logic [CNT_WIDTH-1:0]  align_err_cnt,
    output logic [CNT_WIDTH-1:0]  fft_evt_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALIGN   = 2'd1,
        CAPTURE = 2'd2,
        FULL    = 2'd3
    } state_t;

    state_t            cur_state;
    state_t            nxt_state;
    logic [ADDR_W-1:0] wr_addr;
    logic [IDX_W-1:0]  sample_idx;
    logic              cap_beat;
    logic              arm_take;
    logic              last_addr;
    logic              misplaced;
    logic              any_evt;

    assign cap_beat  = (cur_state == CAPTURE) && s_axis_tvalid;
    assign arm_take  = arm && !abort && ((cur_state == IDLE) || (cur_state == FULL));
    assign last_addr = (wr_addr == ADDR_W'(FRAMES * FFT_LEN - 1));
    // tlast must coincide exactly with the final sample of each frame
    assign misplaced = (sample_idx == IDX_W'(FFT_LEN - 1)) != s_axis_tlast;
    assign any_evt   = |{event_fft_overflow, event_tlast_unexpected, event_tlast_missing};

    always_comb begin
        nxt_state = cur_state;
        if (abort) begin
            nxt_state = IDLE;
        end else begin
            case (cur_state)
                IDLE:    if (arm) nxt_state = ALIGN;
                ALIGN:   if (s_axis_tvalid && s_axis_tlast) nxt_state = CAPTURE;
                CAPTURE: if (cap_beat && last_addr) nxt_state = FULL;
                FULL:    if (arm) nxt_state = ALIGN;
                default: nxt_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= '0;
            wr_addr       <= '0;
            sample_idx    <= '0;
            align_err     <= 1'b0;
            align_err_cnt <= '0;
            fft_evt_cnt   <= '0;
        end else begin
            // a beat taken in the abort cycle is still written
            ram_we <= cap_beat;
            if (cap_beat) begin
                ram_addr  <= wr_addr;
                ram_wdata <= s_axis_tdata;
            end

            if (abort || arm_take) begin
                wr_addr <= '0;
            end else if (cap_beat) begin
                wr_addr <= wr_addr + 1'b1;
            end

            if (arm_take) begin
                sample_idx    <= '0;
                align_err     <= 1'b0;
                align_err_cnt <= '0;
                fft_evt_cnt   <= '0;
            end else begin
                if (cap_beat) begin
                    sample_idx <= sample_idx + 1'b1;
                    if (misplaced) begin
                        align_err <= 1'b1;
                        if (align_err_cnt != '1) align_err_cnt <= align_err_cnt + 1'b1;
                    end
                end
                if ((cur_state == CAPTURE) && any_evt && (fft_evt_cnt != '1)) begin
                    fft_evt_cnt <= fft_evt_cnt + 1'b1;
                end
            end
        end
    end

    assign s_axis_tready = rstn;
    assign full          = (cur_state == FULL);
    assign busy          = (cur_state == ALIGN) || (cur_state == CAPTURE);
    assign state         = cur_state;

endmodule

// File: tb/tb_ospfb_capture_ctrl.sv
// Bench for ospfb_capture_ctrl: table of capture scenarios plus abort/reset sequences,
// with a write scoreboard fed from a behavioural model of the sequencer.
module tb_ospfb_capture_ctrl;

    localparam int FFT_LEN = 8;
    localparam int FRAMES  = 2;
    localparam int TOTAL   = FFT_LEN * FRAMES;

    logic        clk = 1'b0;
    logic        rstn, arm, abort;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [1:0]  event_fft_overflow, event_tlast_unexpected, event_tlast_missing;
    logic        ram_we;
    logic [3:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        full, busy, align_err;
    logic [1:0]  state;
    logic [3:0]  align_err_cnt, fft_evt_cnt;

    ospfb_capture_ctrl #(
        .FFT_LEN(FFT_LEN), .FRAMES(FRAMES), .DATA_WIDTH(32), .NFFT(2), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rstn(rstn), .arm(arm), .abort(abort),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .event_fft_overflow(event_fft_overflow),
        .event_tlast_unexpected(event_tlast_unexpected),
        .event_tlast_missing(event_tlast_missing),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .full(full), .busy(busy), .state(state), .align_err(align_err),
        .align_err_cnt(align_err_cnt), .fft_evt_cnt(fft_evt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int         arm_delay;
        bit         gap;
        int         flip_a;
        int         flip_b;
        bit         flip_all;
        logic [5:0] ev_pat;   // {overflow, tlast_unexpected, tlast_missing}
        int         ev_align;
        int         ev_cap;
        bit         exp_aerr;
        int         exp_acnt;
        int         exp_ecnt;
    } cap_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          nwr = 0;
    int          m_state = 0;
    int          m_addr = 0;
    int          src_pos = 0;
    logic [31:0] src_cnt = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the model to the post-edge state, then check after the edge.
    task automatic cyc(input logic a_arm, input logic a_abort, input logic a_valid,
                       input logic a_flip, input logic [5:0] a_ev, input logic a_rstn);
        logic lst;
        wr_t  e;
        lst = a_valid && ((src_pos == FFT_LEN - 1) ^ a_flip);
        rstn = a_rstn; arm = a_arm; abort = a_abort;
        s_axis_tvalid = a_valid; s_axis_tlast = lst; s_axis_tdata = src_cnt;
        {event_fft_overflow, event_tlast_unexpected, event_tlast_missing} = a_ev;
        if (!a_rstn) begin
            m_state = 0; m_addr = 0;
        end else begin
            if (m_state == 2 && a_valid) begin
                e.addr = 4'(m_addr); e.data = src_cnt;
                exp_q.push_back(e);
            end
            if (a_abort) begin
                m_state = 0; m_addr = 0;
            end else begin
                case (m_state)
                    0: if (a_arm) begin m_state = 1; m_addr = 0; end
                    1: if (a_valid && lst) m_state = 2;
                    2: if (a_valid) begin
                           if (m_addr == TOTAL - 1) m_state = 3;
                           m_addr++;
                       end
                    default: if (a_arm) begin m_state = 1; m_addr = 0; end
                endcase
            end
        end
        if (a_valid) begin
            src_cnt++;
            src_pos = (src_pos + 1) % FFT_LEN;
        end
        @(posedge clk);
        #1;
        if (ram_we === 1'b1) begin
            nwr++;
            if (exp_q.size() == 0) begin
                chk("spurious_ram_we", ram_we, 0);
            end else begin
                e = exp_q.pop_front();
                chk("ram_addr", ram_addr, e.addr);
                chk("ram_wdata", ram_wdata, e.data);
            end
        end
        chk("missing_write", exp_q.size(), 0);
        exp_q.delete();
        chk("state", state, m_state);
        chk("full", full, m_state == 3);
        chk("busy", busy, m_state == 1 || m_state == 2);
    endtask

    task automatic run_capture(input cap_t r);
        int         n0, ev_a, ev_c, budget;
        logic       v, fl;
        logic [5:0] ev;
        n0 = nwr;
        for (int i = 0; i < r.arm_delay; i++) cyc(0, 0, 1, 0, 6'b0, 1);
        cyc(1, 0, 1, 0, 6'b0, 1);
        chk("arm_clear_aerr", align_err, 0);
        chk("arm_clear_acnt", align_err_cnt, 0);
        chk("arm_clear_ecnt", fft_evt_cnt, 0);
        ev_a = r.ev_align; ev_c = r.ev_cap; v = 1'b0; budget = 0;
        while (m_state != 3 && budget < 400) begin
            v = r.gap ? ~v : 1'b1;
            ev = '0;
            if (m_state == 1 && ev_a > 0) begin ev = r.ev_pat; ev_a--; end
            if (m_state == 2 && ev_c > 0) begin ev = r.ev_pat; ev_c--; end
            fl = v && (m_state == 2) && (r.flip_all || m_addr == r.flip_a || m_addr == r.flip_b);
            cyc(0, 0, v, fl, ev, 1);
            budget++;
        end
        chk("reach_full", full, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 6'b0, 1);
        chk("write_count", nwr - n0, TOTAL);
        chk("align_err", align_err, r.exp_aerr);
        chk("align_err_cnt", align_err_cnt, r.exp_acnt);
        chk("fft_evt_cnt", fft_evt_cnt, r.exp_ecnt);
    endtask

    initial begin
        cap_t tbl[6];
        int   budget;
        //        dly gap fa  fb  all ev_pat     eva evc aerr acnt ecnt
        tbl[0] = '{3, 0, -1, -1, 0, 6'b110000, 0, 0,   0, 0,  0};
        tbl[1] = '{0, 0,  5,  7, 0, 6'b110000, 0, 0,   1, 2,  0};
        tbl[2] = '{2, 1, -1, -1, 0, 6'b110000, 0, 0,   0, 0,  0};
        tbl[3] = '{1, 0, -1, -1, 0, 6'b110000, 2, 3,   0, 0,  3};
        tbl[4] = '{0, 1, -1, -1, 1, 6'b000001, 0, 100, 1, 15, 15};
        tbl[5] = '{5, 0, -1, -1, 0, 6'b001000, 3, 5,   0, 0,  5};

        cyc(0, 0, 0, 0, 6'b0, 0);
        cyc(0, 0, 1, 0, 6'b0, 0);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_aerr", align_err, 0);
        chk("rst_acnt", align_err_cnt, 0);
        chk("rst_ecnt", fft_evt_cnt, 0);
        cyc(0, 0, 1, 0, 6'b0, 1);
        chk("tready_after_rst", s_axis_tready, 1);

        for (int i = 0; i < 6; i++) run_capture(tbl[i]);

        // abort mid-capture from a re-arm; arm while capturing is ignored
        cyc(1, 0, 1, 0, 6'b0, 1);
        budget = 0;
        while (!(m_state == 2 && m_addr == 6) && budget < 100) begin
            cyc(m_state == 2 && m_addr == 2, 0, 1, 0, (m_state == 2) ? 6'b110000 : 6'b0, 1);
            budget++;
        end
        chk("abort_pre_state", state, 2);
        cyc(0, 1, 1, 0, 6'b0, 1);
        chk("abort_full", full, 0);
        chk("abort_ecnt_held", fft_evt_cnt, 6);
        cyc(0, 0, 1, 0, 6'b0, 1);
        cyc(0, 0, 1, 0, 6'b0, 1);
        cyc(1, 1, 1, 0, 6'b0, 1);
        chk("arm_abort_state", state, 0);
        chk("arm_abort_ecnt_held", fft_evt_cnt, 6);
        cyc(1, 0, 1, 0, 6'b0, 1);
        cyc(0, 1, 1, 0, 6'b0, 1);
        chk("abort_from_align", state, 0);

        // reset at captured beat 10
        cyc(1, 0, 1, 0, 6'b0, 1);
        budget = 0;
        while (!(m_state == 2 && m_addr == 10) && budget < 100) begin
            cyc(0, 0, 1, 0, (m_state == 2) ? 6'b110000 : 6'b0, 1);
            budget++;
        end
        chk("pre_rst_ecnt", fft_evt_cnt, 10);
        cyc(0, 0, 1, 0, 6'b0, 0);
        chk("midrst_tready", s_axis_tready, 0);
        chk("midrst_ram_we", ram_we, 0);
        chk("midrst_ram_addr", ram_addr, 0);
        chk("midrst_ram_wdata", ram_wdata, 0);
        chk("midrst_ecnt", fft_evt_cnt, 0);
        chk("midrst_acnt", align_err_cnt, 0);
        cyc(0, 0, 1, 0, 6'b0, 1);
        chk("midrst_tready_after", s_axis_tready, 1);
        run_capture(tbl[0]);

        // abort taken from FULL
        cyc(0, 1, 1, 0, 6'b0, 1);
        chk("abort_from_full", full, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ospfb_capture_ctrl.md
Name: ospfb_capture_ctrl

Overview:
Capture sequencer between the OSPFB output AXI-Stream and the capture RAM.
- Once armed, it waits for a frame boundary (tlast), then writes exactly FRAMES*FFT_LEN beats to RAM and raises full.
- While capturing, it checks frame alignment and counts FFT status events.
- It replaces free-running capture, so the bench or host always receives frame-aligned data.

Parameters:
FFT_LEN, 128, beats per OSPFB output frame (power of 2, >=4)
FRAMES, 32, frames per capture (power of 2, >=1)
DATA_WIDTH, 32, width of tdata and RAM word
NFFT, 2, number of FFT instances whose event bits are monitored
CNT_WIDTH, 16, width of saturating error counters

Ports:
clk  in  1  single clock; all logic on rising edge
rstn  in  1  synchronous, active-low reset
arm  in  1  pulse: start or restart a capture (acted on in IDLE and FULL)
abort  in  1  pulse: return to IDLE from any state; higher priority than arm
s_axis_tdata  in  DATA_WIDTH  OSPFB output sample
s_axis_tvalid  in  1  sample valid
s_axis_tlast  in  1  last beat of frame
s_axis_tready  out  1  always 1 outside reset; the sink never back-pressures
event_fft_overflow  in  NFFT  FFT status event bits
event_tlast_unexpected  in  NFFT  FFT status event bits
event_tlast_missing  in  NFFT  FFT status event bits
ram_we  out  1  registered RAM write enable
ram_addr  out  log2(FRAMES*FFT_LEN)  registered RAM write address
ram_wdata  out  DATA_WIDTH  registered RAM write data
full  out  1  capture complete, RAM holds FRAMES frames
busy  out  1  state is ALIGN or CAPTURE
state  out  2  IDLE=0, ALIGN=1, CAPTURE=2, FULL=3
align_err  out  1  sticky: a tlast was misplaced during capture
align_err_cnt  out  CNT_WIDTH  saturating count of misplaced or missing tlast
fft_evt_cnt  out  CNT_WIDTH  saturating count of cycles with any event bit set during CAPTURE

Behaviour:
- Beat: a cycle with s_axis_tvalid=1 (tready is always 1).
- Reset (rstn=0 at a clk edge), next cycle:
  - state=IDLE; ram_we=0, ram_addr=0, ram_wdata=0.
  - full=0, busy=0, align_err=0, all counters=0.
  - s_axis_tready=0 while rstn=0, and 1 from the first cycle after reset deasserts.
  - Reset mid-capture aborts the capture; RAM contents are not cleared.
- IDLE:
  - No writes.
  - arm -> ALIGN. Entering ALIGN clears wr_addr, sample_idx, align_err and both counters.
- ALIGN:
  - Beats are discarded.
  - A beat with tlast=1 -> CAPTURE on the next cycle.
  - The first captured beat is the first beat after that tlast. The tlast beat itself is not written.
- CAPTURE, for each beat:
  - Registered write of tdata to wr_addr; ram_we pulses 1 cycle later with ram_addr=wr_addr and ram_wdata=tdata. Latency is 1 cycle.
  - wr_addr increments; sample_idx increments modulo FFT_LEN.
  - Alignment check: if sample_idx=FFT_LEN-1 and tlast=0, or sample_idx!=FFT_LEN-1 and tlast=1, set align_err=1 and increment align_err_cnt (saturating).
  - Misalignment does not resynchronise or stop the capture.
  - Any cycle in CAPTURE where the OR of all event bits is 1 increments fft_evt_cnt (saturating at 2^CNT_WIDTH-1). This counts cycles, not bits.
  - Beat with wr_addr=FRAMES*FFT_LEN-1 -> FULL.
  - Gaps (tvalid=0) do not advance anything.
- FULL:
  - full=1 from the same cycle as the final ram_we pulse until an arm or abort is taken.
  - No writes; beats are discarded.
  - arm -> ALIGN (re-arm, full clears next cycle).
- abort in any state -> IDLE next cycle:
  - full=0; wr_addr=0.
  - A write already registered from the abort cycle's beat still completes (ram_we=1 that one cycle).
  - Counters and align_err are held until the next arm.
- Priority and boundary cases:
  - abort and arm in the same cycle: abort wins.
  - arm in ALIGN or CAPTURE is ignored.
  - Counters hold at their maximum and never wrap.
- busy = (state==ALIGN) or (state==CAPTURE), derived from registered state.
- No combinational path from any input to any output except s_axis_tready.

Test Plan (FFT_LEN=8, FRAMES=2, continuous tvalid, tdata=incrementing count, tlast every 8th beat):
- Normal capture: arm after 3 beats -> data beginning at the first beat after the next tlast is written to addresses 0..15; 16 ram_we pulses; full=1 coincident with the ram_addr=15 write; align_err=0; state=3.
- Misaligned tlast: tlast asserted on captured beat index 5 of frame 0 and dropped at index 7 -> align_err=1, align_err_cnt=2, full still reached after 16 beats.
- Gapped input: tvalid toggling 1/0 -> 16 writes with contiguous addresses; full asserted after 32 beat-cycles; no duplicate addresses.
- FFT events: event_fft_overflow=2'b11 for 3 cycles during CAPTURE, plus 2 cycles in ALIGN -> fft_evt_cnt=3. Re-arm -> counter reads 0 in ALIGN.
- Abort: abort at captured beat 6 -> at most one further ram_we pulse, then state=IDLE, full=0. A subsequent arm+abort in the same cycle leaves state=IDLE.
- Reset mid-capture: rstn=0 for 1 cycle at beat 10 -> all outputs at reset values next cycle; tready=0 during reset; a later arm produces a correct capture starting at address 0.
